// File: rtl/seq_datapath_pkg.sv
// Shared definitions for the sequenced datapath: ALU op codes, the
// micro-step sequencer state encoding and a constant-evaluable clog2.
package datapath_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_NOT  = 4'd5;
  localparam logic [3:0] OP_NEG  = 4'd6;
  localparam logic [3:0] OP_SHL  = 4'd7;
  localparam logic [3:0] OP_SHR  = 4'd8;
  localparam logic [3:0] OP_SHRA = 4'd9;
  localparam logic [3:0] OP_ROR  = 4'd10;
  localparam logic [3:0] OP_MOV  = 4'd11;

  typedef enum logic [1:0] {IDLE, T_Y, T_Z, T_WB} state_t;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++)
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/seq_datapath_if.sv
// Command bus of the sequenced datapath.
//   master: issues cmd_* fields, observes cmd_ready, done, result, flags.
//   slave : the datapath side.
interface seq_datapath_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned RW    = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [3:0]       cmd_op;
  logic [RW-1:0]    cmd_ra;
  logic [RW-1:0]    cmd_rb;
  logic [RW-1:0]    cmd_rd;
  logic             cmd_use_imm;
  logic [WIDTH-1:0] cmd_imm;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             flag_z;
  logic             flag_n;
  logic             flag_c;

  modport master (
    output cmd_valid, cmd_op, cmd_ra, cmd_rb, cmd_rd, cmd_use_imm, cmd_imm,
    input  cmd_ready, done, result, flag_z, flag_n, flag_c
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_ra, cmd_rb, cmd_rd, cmd_use_imm, cmd_imm,
    output cmd_ready, done, result, flag_z, flag_n, flag_c
  );
endinterface

// File: rtl/seq_datapath_alu.sv
// alu_param: combinational ALU shared by the datapath sequencer.
//   a, b  : operands (a = Y register, b = bus)
//   op    : operation code (12..15 produce z=0, carry=0; caller treats as NOP)
//   z     : result, carry : carry-out for ADD, no-borrow for SUB, else 0
module alu_param
  import datapath_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic [WIDTH-1:0] z,
  output logic             carry
);
  localparam int unsigned SW = clog2(WIDTH);

  logic [SW-1:0]  sh;
  logic [SW:0]    lsh;
  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;

  always_comb begin
    sh   = b[SW-1:0];
    // a << WIDTH is zero, so a zero rotate needs no special case.
    lsh  = (SW+1)'(WIDTH) - {1'b0, sh};
    sum  = {1'b0, a} + {1'b0, b};
    // Two's-complement subtract: the top bit is set exactly when a >= b.
    diff = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
    z     = '0;
    carry = 1'b0;
    case (op)
      OP_ADD:  begin z = sum[WIDTH-1:0];  carry = sum[WIDTH];  end
      OP_SUB:  begin z = diff[WIDTH-1:0]; carry = diff[WIDTH]; end
      OP_AND:  z = a & b;
      OP_OR:   z = a | b;
      OP_XOR:  z = a ^ b;
      OP_NOT:  z = ~a;
      OP_NEG:  z = '0 - a;
      OP_SHL:  z = a << sh;
      OP_SHR:  z = a >> sh;
      OP_SHRA: z = $signed(a) >>> sh;
      OP_ROR:  z = (a >> sh) | (a << lsh);
      OP_MOV:  z = b;
      default: z = '0;
    endcase
  end
endmodule

// File: rtl/seq_datapath.sv
// seq_datapath: register file, Y/Z holding registers and a single internal
// bus driven by a four-step sequencer (IDLE -> T_Y -> T_Z -> T_WB).
//   clock, clear    : rising-edge clock, synchronous active-high reset
//   cmd             : command bus (slave side), done/result/flags
//   ext_wr_*        : external register load port
//   dbg_sel/dbg_data: combinational register read for bring-up
module seq_datapath
  import datapath_pkg::*;
#(
  parameter  int unsigned WIDTH   = 32,
  parameter  int unsigned NREGS   = 16,
  parameter  bit          R0_ZERO = 1'b1,
  localparam int unsigned RW      = clog2(NREGS)
) (
  input  logic             clock,
  input  logic             clear,
  seq_datapath_if.slave    cmd,
  input  logic             ext_wr_en,
  input  logic [RW-1:0]    ext_wr_sel,
  input  logic [WIDTH-1:0] ext_wr_data,
  input  logic [RW-1:0]    dbg_sel,
  output logic [WIDTH-1:0] dbg_data
);
  state_t           state, state_nx;
  logic [3:0]       op_q;
  logic [RW-1:0]    ra_q, rb_q, rd_q;
  logic             use_imm_q;
  logic [WIDTH-1:0] imm_q;
  logic [WIDTH-1:0] regs [NREGS];
  logic [WIDTH-1:0] y_q, z_q;
  logic             c_q;
  logic             done_q;
  logic [WIDTH-1:0] result_q;
  logic             fz_q, fn_q, fc_q;

  logic [WIDTH-1:0] ra_val, rb_val, bus, alu_z;
  logic             alu_c, is_nop, wb_en, ext_en;

  always_comb begin
    ra_val   = (R0_ZERO && ra_q == '0) ? '0 : regs[ra_q];
    rb_val   = (R0_ZERO && rb_q == '0) ? '0 : regs[rb_q];
    dbg_data = (R0_ZERO && dbg_sel == '0) ? '0 : regs[dbg_sel];
  end

  always_comb begin
    bus = '0;
    case (state)
      T_Y:     bus = ra_val;
      T_Z:     bus = use_imm_q ? imm_q : rb_val;
      T_WB:    bus = z_q;
      default: bus = '0;
    endcase
  end

  alu_param #(.WIDTH(WIDTH)) u_alu (
    .a     (y_q),
    .b     (bus),
    .op    (op_q),
    .z     (alu_z),
    .carry (alu_c)
  );

  always_comb begin
    is_nop = (op_q[3:2] == 2'b11);
    wb_en  = (state == T_WB) && !is_nop && !(R0_ZERO && rd_q == '0);
    ext_en = ext_wr_en && !(R0_ZERO && ext_wr_sel == '0);
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (cmd.cmd_valid) state_nx = T_Y;
      T_Y:     state_nx = T_Z;
      T_Z:     state_nx = T_WB;
      T_WB:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state     <= IDLE;
      op_q      <= '0;
      ra_q      <= '0;
      rb_q      <= '0;
      rd_q      <= '0;
      use_imm_q <= 1'b0;
      imm_q     <= '0;
      y_q       <= '0;
      z_q       <= '0;
      c_q       <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
      fz_q      <= 1'b0;
      fn_q      <= 1'b0;
      fc_q      <= 1'b0;
    end else begin
      state  <= state_nx;
      done_q <= (state == T_WB);
      if (state == IDLE && cmd.cmd_valid) begin
        op_q      <= cmd.cmd_op;
        ra_q      <= cmd.cmd_ra;
        rb_q      <= cmd.cmd_rb;
        rd_q      <= cmd.cmd_rd;
        use_imm_q <= cmd.cmd_use_imm;
        imm_q     <= cmd.cmd_imm;
      end
      if (state == T_Y) y_q <= bus;
      if (state == T_Z) begin
        z_q <= alu_z;
        c_q <= alu_c;
      end
      if (state == T_WB && !is_nop) begin
        result_q <= bus;
        fz_q     <= (bus == '0);
        fn_q     <= bus[WIDTH-1];
        fc_q     <= c_q;
      end
    end
  end

  // The sequencer write is placed after the external one so that it wins
  // when both target the same register on the same edge.
  always_ff @(posedge clock) begin
    if (clear) begin
      for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      if (ext_en) regs[ext_wr_sel] <= ext_wr_data;
      if (wb_en)  regs[rd_q]       <= bus;
    end
  end

  assign cmd.cmd_ready = (state == IDLE);
  assign cmd.done      = done_q;
  assign cmd.result    = result_q;
  assign cmd.flag_z    = fz_q;
  assign cmd.flag_n    = fn_q;
  assign cmd.flag_c    = fc_q;
endmodule

// File: tb/tb_seq_datapath.sv
module tb_seq_datapath;
  logic        clock;
  logic        clear;
  logic        ext_wr_en;
  logic [3:0]  ext_wr_sel;
  logic [31:0] ext_wr_data;
  logic [3:0]  dbg_sel;
  logic [31:0] dbg_data;

  seq_datapath_if #(.WIDTH(32), .RW(4)) cmd_if ();

  seq_datapath #(.WIDTH(32), .NREGS(16), .R0_ZERO(1'b1)) dut (
    .clock       (clock),
    .clear       (clear),
    .cmd         (cmd_if),
    .ext_wr_en   (ext_wr_en),
    .ext_wr_sel  (ext_wr_sel),
    .ext_wr_data (ext_wr_data),
    .dbg_sel     (dbg_sel),
    .dbg_data    (dbg_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  // Reference state: architectural registers and last-result flags.
  logic [31:0] m [16];
  logic [31:0] m_res;
  logic        m_z, m_n, m_c;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Behavioural ALU written from the operation table with plain arithmetic.
  task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] z, output logic c, output bit nop);
    longint unsigned s;
    int sh;
    sh  = int'(b % 32);
    z   = 32'h0;
    c   = 1'b0;
    nop = 1'b0;
    case (op)
      4'd0:  begin s = 64'(a) + 64'(b); z = 32'(s); c = (s >= 64'h1_0000_0000); end
      4'd1:  begin z = a - b; c = (a >= b); end
      4'd2:  z = a & b;
      4'd3:  z = a | b;
      4'd4:  z = a ^ b;
      4'd5:  z = ~a;
      4'd6:  z = 32'd0 - a;
      4'd7:  z = a << sh;
      4'd8:  z = a >> sh;
      4'd9:  begin
               z = a >> sh;
               if (a[31] && sh > 0) z = z | ~(32'hFFFF_FFFF >> sh);
             end
      4'd10: begin
               z = a;
               for (int k = 0; k < sh; k++) z = {z[0], z[31:1]};
             end
      4'd11: z = b;
      default: nop = 1'b1;
    endcase
  endtask

  task automatic check_reg(input int idx, input string tag);
    dbg_sel = 4'(idx);
    #1;
    chk(tag, dbg_data, m[idx]);
  endtask

  task automatic ext_write(input int sel, input logic [31:0] data);
    @(negedge clock);
    ext_wr_en   = 1'b1;
    ext_wr_sel  = 4'(sel);
    ext_wr_data = data;
    @(posedge clock);
    #1;
    ext_wr_en = 1'b0;
    if (sel != 0) m[sel] = data;
  endtask

  task automatic run_cmd(input logic [3:0] op, input int ra, input int rb, input int rd,
                         input bit ui, input logic [31:0] imm,
                         input bit wbx, input int wbx_sel, input logic [31:0] wbx_data);
    logic [31:0] a, b, z;
    logic        c;
    bit          nop;
    int          lat;
    a = m[ra];
    b = ui ? imm : m[rb];
    model(op, a, b, z, c, nop);
    @(negedge clock);
    chk("ready_before", {31'd0, cmd_if.cmd_ready}, 32'd1);
    cmd_if.cmd_valid   = 1'b1;
    cmd_if.cmd_op      = op;
    cmd_if.cmd_ra      = 4'(ra);
    cmd_if.cmd_rb      = 4'(rb);
    cmd_if.cmd_rd      = 4'(rd);
    cmd_if.cmd_use_imm = ui;
    cmd_if.cmd_imm     = imm;
    @(posedge clock);
    #1;
    cmd_if.cmd_valid = 1'b0;
    lat = 0;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      @(negedge clock);
      if (wbx && cyc == 3) begin
        ext_wr_en   = 1'b1;
        ext_wr_sel  = 4'(wbx_sel);
        ext_wr_data = wbx_data;
      end
      @(posedge clock);
      #1;
      ext_wr_en = 1'b0;
      if (cmd_if.done) begin
        lat = cyc;
        break;
      end
    end
    chk("latency", 32'(lat), 32'd3);
    if (wbx && wbx_sel != 0) m[wbx_sel] = wbx_data;
    if (!nop) begin
      if (rd != 0) m[rd] = z;
      m_res = z;
      m_z   = (z == 32'd0);
      m_n   = z[31];
      m_c   = c;
    end
    chk("result", cmd_if.result, m_res);
    chk("flag_z", {31'd0, cmd_if.flag_z}, {31'd0, m_z});
    chk("flag_n", {31'd0, cmd_if.flag_n}, {31'd0, m_n});
    chk("flag_c", {31'd0, cmd_if.flag_c}, {31'd0, m_c});
    chk("ready_after", {31'd0, cmd_if.cmd_ready}, 32'd1);
    check_reg(rd, "reg_rd");
    if (wbx) check_reg(wbx_sel, "reg_wbx");
    @(posedge clock);
    #1;
    chk("done_width", {31'd0, cmd_if.done}, 32'd0);
  endtask

  initial begin
    int d_at [3];
    int d_cnt;
    bit seen;

    clear              = 1'b1;
    ext_wr_en          = 1'b0;
    ext_wr_sel         = '0;
    ext_wr_data        = '0;
    dbg_sel            = '0;
    cmd_if.cmd_valid   = 1'b0;
    cmd_if.cmd_op      = '0;
    cmd_if.cmd_ra      = '0;
    cmd_if.cmd_rb      = '0;
    cmd_if.cmd_rd      = '0;
    cmd_if.cmd_use_imm = 1'b0;
    cmd_if.cmd_imm     = '0;
    for (int i = 0; i < 16; i++) m[i] = 32'd0;
    m_res = 32'd0; m_z = 1'b0; m_n = 1'b0; m_c = 1'b0;

    // Reset state
    @(posedge clock);
    @(posedge clock);
    #1;
    chk("rst_ready", {31'd0, cmd_if.cmd_ready}, 32'd1);
    chk("rst_done", {31'd0, cmd_if.done}, 32'd0);
    chk("rst_result", cmd_if.result, 32'd0);
    chk("rst_flags", {29'd0, cmd_if.flag_z, cmd_if.flag_n, cmd_if.flag_c}, 32'd0);
    for (int i = 0; i < 16; i++) check_reg(i, "rst_reg");
    @(negedge clock);
    clear = 1'b0;

    // Basic ADD
    ext_write(1, 32'd5);
    ext_write(2, 32'd3);
    run_cmd(4'd0, 1, 2, 3, 1'b0, 32'd0, 1'b0, 0, 32'd0);

    // Carry / borrow boundaries
    ext_write(4, 32'hFFFF_FFFF);
    run_cmd(4'd0, 4, 0, 5, 1'b1, 32'd1, 1'b0, 0, 32'd0);
    run_cmd(4'd1, 5, 4, 7, 1'b0, 32'd0, 1'b0, 0, 32'd0);

    // Arithmetic shift, NOP leaves result/flags, rotate amount wraps
    ext_write(6, 32'h8000_0000);
    run_cmd(4'd9, 6, 0, 8, 1'b1, 32'd4, 1'b0, 0, 32'd0);
    run_cmd(4'd13, 1, 2, 9, 1'b0, 32'd0, 1'b0, 0, 32'd0);
    run_cmd(4'd10, 6, 0, 9, 1'b1, 32'd36, 1'b0, 0, 32'd0);

    // R0 hard-wired zero
    run_cmd(4'd11, 1, 0, 0, 1'b1, 32'h1234, 1'b0, 0, 32'd0);
    ext_write(0, 32'd7);
    check_reg(0, "r0_ext");

    // Randomised commands against the reference model
    for (int t = 0; t < 40; t++) begin
      logic [31:0] imm;
      imm = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 63)) : $urandom;
      if ($urandom_range(0, 1) == 1) ext_write($urandom_range(0, 15), $urandom);
      run_cmd(4'($urandom_range(0, 15)), $urandom_range(0, 15), $urandom_range(0, 15),
              $urandom_range(0, 15), 1'($urandom_range(0, 1)), imm, 1'b0, 0, 32'd0);
    end

    // Back-to-back: valid held high, R10 += 1 per command
    ext_write(10, 32'd100);
    @(negedge clock);
    cmd_if.cmd_valid   = 1'b1;
    cmd_if.cmd_op      = 4'd0;
    cmd_if.cmd_ra      = 4'd10;
    cmd_if.cmd_rb      = 4'd0;
    cmd_if.cmd_rd      = 4'd10;
    cmd_if.cmd_use_imm = 1'b1;
    cmd_if.cmd_imm     = 32'd1;
    d_cnt = 0;
    for (int c = 0; c < 14; c++) begin
      @(posedge clock);
      #1;
      if (cmd_if.done) begin
        if (d_cnt < 3) d_at[d_cnt] = c;
        d_cnt++;
      end
    end
    @(negedge clock);
    cmd_if.cmd_valid = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 8 && !seen; c++) begin
      @(posedge clock);
      #1;
      if (cmd_if.done) seen = 1'b1;
    end
    chk("b2b_count", 32'(d_cnt), 32'd3);
    if (d_cnt >= 3) begin
      chk("b2b_first", 32'(d_at[0]), 32'd3);
      chk("b2b_gap1", 32'(d_at[1] - d_at[0]), 32'd4);
      chk("b2b_gap2", 32'(d_at[2] - d_at[1]), 32'd4);
    end
    chk("b2b_drain", {31'd0, seen}, 32'd1);
    m[10] = 32'd104; m_res = 32'd104; m_z = 1'b0; m_n = 1'b0; m_c = 1'b0;
    check_reg(10, "b2b_reg");
    chk("b2b_result", cmd_if.result, m_res);

    // Clear while in T_Z aborts the command
    @(negedge clock);
    cmd_if.cmd_valid   = 1'b1;
    cmd_if.cmd_op      = 4'd0;
    cmd_if.cmd_ra      = 4'd1;
    cmd_if.cmd_rd      = 4'd11;
    cmd_if.cmd_use_imm = 1'b1;
    cmd_if.cmd_imm     = 32'd5;
    @(posedge clock);
    #1;
    cmd_if.cmd_valid = 1'b0;
    @(posedge clock);
    @(negedge clock);
    clear = 1'b1;
    @(posedge clock);
    #1;
    for (int i = 0; i < 16; i++) m[i] = 32'd0;
    m_res = 32'd0; m_z = 1'b0; m_n = 1'b0; m_c = 1'b0;
    chk("clr_ready", {31'd0, cmd_if.cmd_ready}, 32'd1);
    chk("clr_done", {31'd0, cmd_if.done}, 32'd0);
    chk("clr_result", cmd_if.result, 32'd0);
    chk("clr_flags", {29'd0, cmd_if.flag_z, cmd_if.flag_n, cmd_if.flag_c}, 32'd0);
    for (int i = 0; i < 16; i++) check_reg(i, "clr_reg");
    @(negedge clock);
    clear = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clock);
      #1;
      if (cmd_if.done) seen = 1'b1;
    end
    chk("clr_no_done", {31'd0, seen}, 32'd0);

    // Writeback collision: sequencer wins on rd, other target still lands
    ext_write(1, 32'd9);
    ext_write(2, 32'd4);
    run_cmd(4'd0, 1, 2, 3, 1'b0, 32'd0, 1'b1, 3, 32'hAA);
    run_cmd(4'd3, 1, 2, 4, 1'b0, 32'd0, 1'b1, 12, 32'h55);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
